// File: rtl/multiplexor_2to1_pkg.sv
// Shared constants and select encoding for the 2:1 word multiplexor slice.
package multiplexor_2to1_pkg;

  localparam int unsigned MUX_WIDTH_DEFAULT = 5;

  typedef enum logic {
    SEL_IN0 = 1'b0,
    SEL_IN1 = 1'b1
  } mux_sel_e;

endpackage : multiplexor_2to1_pkg

// File: rtl/mux_pipe_reg.sv
// Async active-low reset register with capture enable; holds when en is low.
module mux_pipe_reg
  import multiplexor_2to1_pkg::*;
#(
  parameter int unsigned W = MUX_WIDTH_DEFAULT + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : mux_pipe_reg

// File: rtl/multiplexor_2to1.sv
// Parameterised 2:1 word multiplexor: combinational select plus a registered
// copy of the selected word and select bit for pipelined consumers.
module multiplexor_2to1
  import multiplexor_2to1_pkg::*;
#(
  parameter int unsigned WIDTH = MUX_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             en,
  output logic [WIDTH-1:0] mux_out,
  output logic [WIDTH-1:0] mux_out_q,
  output logic             sel_q
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_width_check
    $error("multiplexor_2to1: WIDTH must be in 1..64");
  end

  mux_sel_e         sel_e;
  logic [WIDTH:0]   pipe_d;
  logic [WIDTH:0]   pipe_q;

  assign sel_e = mux_sel_e'(sel);

  // Conditional operator keeps X-select merge semantics: agreeing bits pass, others go X.
  always_comb begin
    mux_out = (sel_e == SEL_IN1) ? in1 : in0;
  end

  assign pipe_d = {sel, mux_out};

  mux_pipe_reg #(
    .W (WIDTH + 1)
  ) u_pipe_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .d     (pipe_d),
    .q     (pipe_q)
  );

  assign mux_out_q = pipe_q[WIDTH-1:0];
  assign sel_q     = pipe_q[WIDTH];

endmodule : multiplexor_2to1

// File: tb/tb_multiplexor_2to1.sv
// Self-checking bench for multiplexor_2to1: directed cases plus randomized
// traffic against a behavioural reference.
module tb_multiplexor_2to1;

  localparam int unsigned W = 5;

  logic         clk;
  logic         rst_n;
  logic         sel;
  logic [W-1:0] in0;
  logic [W-1:0] in1;
  logic         en;
  logic [W-1:0] mux_out;
  logic [W-1:0] mux_out_q;
  logic         sel_q;

  int unsigned  n_checks;
  int unsigned  n_fail;

  logic [W-1:0] exp_q;
  logic         exp_sel_q;

  multiplexor_2to1 #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel       (sel),
    .in0       (in0),
    .in1       (in1),
    .en        (en),
    .mux_out   (mux_out),
    .mux_out_q (mux_out_q),
    .sel_q     (sel_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: the select bit indexes a two-entry table of input words.
  function automatic logic [W-1:0] ref_mux(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] words [2];
    words[0] = a;
    words[1] = b;
    return words[s];
  endfunction

  task automatic drive_comb(input bit s, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    sel = s;
    in0 = a;
    in1 = b;
    #1;
    check_val(tag, 64'(mux_out), 64'(ref_mux(s, a, b)));
  endtask

  // Advance one clock edge, update the register model from pre-edge inputs, check.
  task automatic clock_and_check(input string tag);
    logic [W-1:0] pre_word;
    logic         pre_sel;
    pre_word = ref_mux(sel, in0, in1);
    pre_sel  = sel;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      exp_q     = '0;
      exp_sel_q = 1'b0;
    end else if (en) begin
      exp_q     = pre_word;
      exp_sel_q = pre_sel;
    end
    check_val({tag, "_q"}, 64'(mux_out_q), 64'(exp_q));
    check_val({tag, "_selq"}, 64'(sel_q), 64'(exp_sel_q));
  endtask

  initial begin
    logic [W-1:0] agree;
    n_checks  = 0;
    n_fail    = 0;
    exp_q     = '0;
    exp_sel_q = 1'b0;
    rst_n     = 1'b0;
    en        = 1'b0;
    sel       = 1'b0;
    in0       = '0;
    in1       = '0;

    #2;
    check_val("reset_q", 64'(mux_out_q), 64'h0);
    check_val("reset_selq", 64'(sel_q), 64'h0);

    // Combinational path tracks inputs even while reset is asserted.
    drive_comb(1'b0, 5'h15, 5'h03, "comb_sel0_a");
    drive_comb(1'b0, 5'h0A, 5'h1C, "comb_sel0_b");
    drive_comb(1'b1, 5'h01, 5'h15, "comb_sel1_a");
    drive_comb(1'b1, 5'h15, 5'h0A, "comb_sel1_b");
    sel = 1'b0;
    #1;
    check_val("comb_toggle", 64'(mux_out), 64'h15);

    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    drive_comb(1'b1, 5'h15, 5'h0A, "comb_pre_cap");
    clock_and_check("cap_0a");
    check_val("cap_0a_abs", 64'(mux_out_q), 64'h0A);

    // Async reset mid-cycle, no clock edge involved.
    #2;
    rst_n = 1'b0;
    #1;
    exp_q     = '0;
    exp_sel_q = 1'b0;
    check_val("async_rst_q", 64'(mux_out_q), 64'h0);
    check_val("async_rst_selq", 64'(sel_q), 64'h0);
    drive_comb(1'b0, 5'h07, 5'h19, "comb_in_reset");
    clock_and_check("rst_held_edge");

    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    drive_comb(1'b1, 5'h00, 5'h1F, "comb_1f");
    clock_and_check("post_rst_cap");
    check_val("post_rst_abs", 64'(mux_out_q), 64'h1F);
    check_val("post_rst_sel", 64'(sel_q), 64'h1);

    // Enable low: registers hold across several edges.
    @(negedge clk);
    en = 1'b0;
    drive_comb(1'b0, 5'h03, 5'h11, "comb_03");
    for (int i = 0; i < 3; i++) begin
      clock_and_check("hold");
      check_val("hold_abs", 64'(mux_out_q), 64'h1F);
    end
    @(negedge clk);
    en = 1'b1;
    clock_and_check("resume");
    check_val("resume_abs", 64'(mux_out_q), 64'h03);

    // Unknown select: bits where both inputs agree must still resolve.
    @(negedge clk);
    in0 = 5'h15;
    in1 = 5'h05;
    sel = 1'bx;
    #1;
    agree = ~(in0 ^ in1);
    check_val("xsel_agree", 64'(mux_out & agree), 64'(in0 & agree));
    sel = 1'b0;
    #1;

    // Randomized traffic with occasional async reset pulses.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rst_n = 1'b1;
      en    = ($urandom_range(0, 3) != 0);
      drive_comb(1'($urandom), W'($urandom), W'($urandom), "rnd_comb");
      if ($urandom_range(0, 24) == 0) begin
        rst_n = 1'b0;
        #1;
        exp_q     = '0;
        exp_sel_q = 1'b0;
        check_val("rnd_async_q", 64'(mux_out_q), 64'h0);
        check_val("rnd_async_selq", 64'(sel_q), 64'h0);
        if ($urandom_range(0, 1) == 0) rst_n = 1'b1;
      end
      clock_and_check("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_multiplexor_2to1
